// File: rtl/vigna_prefetch_if.sv
// Instruction bus, fetch-queue head and redirect signals of the vigna prefetch unit.
interface vigna_prefetch_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_inst;
    logic [31:0] f_addr;
    logic        redirect_valid;
    logic [31:0] redirect_addr;

    modport master (
        output i_valid, i_addr, i_wdata, i_wstrb, f_valid, f_inst, f_addr,
        input  i_ready, i_rdata, f_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  i_valid, i_addr, i_wdata, i_wstrb, f_valid, f_inst, f_addr,
        output i_ready, i_rdata, f_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/vigna_prefetch.sv
// Instruction prefetch unit: DEPTH-entry queue fed by a single-outstanding
// valid/ready fetch bus, flushed by branch/jump redirects.
module vigna_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input logic             clk,
    input logic             reset,
    vigna_prefetch_if.master bus
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    logic          i_valid_q, i_valid_d;
    logic [31:0]   i_addr_q, i_addr_d;
    logic [31:0]   pc_q, pc_d;
    logic          discard_q, discard_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [31:0]   qaddr_q [DEPTH];
    logic [31:0]   qinst_q [DEPTH];

    logic          complete, pop, push, f_valid;
    logic [PW:0]   cnt_nxt;
    logic [31:0]   target;

    assign f_valid  = (count_q != '0);
    assign complete = i_valid_q && bus.i_ready;
    assign pop      = f_valid && bus.f_ready;
    assign target   = bus.redirect_addr & ~32'h3;

    assign bus.i_valid = i_valid_q;
    assign bus.i_addr  = i_addr_q;
    assign bus.i_wdata = '0;
    assign bus.i_wstrb = '0;
    assign bus.f_valid = f_valid;
    assign bus.f_inst  = qinst_q[rptr_q];
    assign bus.f_addr  = qaddr_q[rptr_q];

    always_comb begin
        i_valid_d = i_valid_q;
        i_addr_d  = i_addr_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        count_d   = count_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        push      = 1'b0;
        cnt_nxt   = count_q;

        if (bus.redirect_valid) begin
            count_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
            // A stalled request cannot be aborted; its word is dropped when it lands.
            if (i_valid_q && !bus.i_ready) begin
                discard_d = 1'b1;
                pc_d      = target;
            end else begin
                discard_d = 1'b0;
                i_valid_d = 1'b1;
                i_addr_d  = target;
                pc_d      = target + 32'd4;
            end
        end else begin
            push = complete && !discard_q;
            if (complete)
                discard_d = 1'b0;
            cnt_nxt = count_q + (PW+1)'(push) - (PW+1)'(pop);
            count_d = cnt_nxt;
            if (push)
                wptr_d = wptr_q + PW'(1);
            if (pop)
                rptr_d = rptr_q + PW'(1);
            if ((!i_valid_q || complete) && (cnt_nxt < DEPTH_C)) begin
                i_valid_d = 1'b1;
                i_addr_d  = pc_q;
                pc_d      = pc_q + 32'd4;
            end else if (complete) begin
                i_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_valid_q <= 1'b0;
            i_addr_q  <= RESET_ADDR;
            pc_q      <= RESET_ADDR;
            discard_q <= 1'b0;
            count_q   <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                qaddr_q[i] <= '0;
                qinst_q[i] <= '0;
            end
        end else begin
            i_valid_q <= i_valid_d;
            i_addr_q  <= i_addr_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            if (push) begin
                qaddr_q[wptr_q] <= i_addr_q;
                qinst_q[wptr_q] <= bus.i_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vigna_prefetch.sv
// Directed bench for vigna_prefetch: streaming, backpressure, redirects, wrap, async reset.
module tb_vigna_prefetch;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    vigna_prefetch_if bus ();

    vigna_prefetch #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: instruction word is a fixed function of its address.
    assign bus.i_rdata = bus.i_addr ^ 32'hA5A5_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic iready, input logic fready);
        reset              = 1'b1;
        bus.i_ready        = iready;
        bus.f_ready        = fready;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checks++; if (bus.i_valid !== 1'b0) begin failures++; $display("FAIL rst_ivalid got=%b exp=0", bus.i_valid); end
        checks++; if (bus.i_addr !== 32'h0) begin failures++; $display("FAIL rst_iaddr got=%h exp=00000000", bus.i_addr); end
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL rst_fvalid got=%b exp=0", bus.f_valid); end
        checks++; if (bus.f_inst !== 32'h0) begin failures++; $display("FAIL rst_finst got=%h exp=00000000", bus.f_inst); end
        checks++; if (bus.f_addr !== 32'h0) begin failures++; $display("FAIL rst_faddr got=%h exp=00000000", bus.f_addr); end
        checks++; if (bus.i_wdata !== 32'h0 || bus.i_wstrb !== 4'h0) begin failures++; $display("FAIL rst_wr got=%h/%h exp=0/0", bus.i_wdata, bus.i_wstrb); end
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/00000000", bus.i_valid, bus.i_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        do_reset(1'b1, 1'b1);
        step();
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL stream_lat got=%b exp=0", bus.f_valid); end
        for (int k = 0; k < 8; k++) begin
            step();
            ea = 32'(4 * k);
            checks++; if (bus.f_valid !== 1'b1 || bus.f_addr !== ea) begin failures++; $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, bus.f_valid, bus.f_addr, ea); end
            checks++; if (bus.f_inst !== (ea ^ 32'hA5A5_0000)) begin failures++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, bus.f_inst, ea ^ 32'hA5A5_0000); end
            checks++; if (bus.i_valid !== 1'b1) begin failures++; $display("FAIL stream_b2b k=%0d got=%b exp=1", k, bus.i_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ea;
        do_reset(1'b1, 1'b0);
        repeat (5) step();
        checks++; if (bus.i_valid !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", bus.i_valid); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.i_valid !== 1'b0 || bus.f_addr !== 32'h0) begin failures++; $display("FAIL bp_hold k=%0d got=%b/%h exp=0/00000000", k, bus.i_valid, bus.f_addr); end
        end
        bus.f_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            ea = 32'(4 * (j + 1));
            checks++; if (bus.f_valid !== 1'b1 || bus.f_addr !== ea || bus.f_inst !== (ea ^ 32'hA5A5_0000)) begin failures++; $display("FAIL bp_resume j=%0d got=%b/%h/%h exp=1/%h", j, bus.f_valid, bus.f_addr, bus.f_inst, ea); end
        end
    endtask

    task automatic test_redirect_stall();
        do_reset(1'b1, 1'b1);
        repeat (3) step();
        checks++; if (bus.i_addr !== 32'h8 || bus.f_addr !== 32'h4) begin failures++; $display("FAIL rs_setup got=%h/%h exp=00000008/00000004", bus.i_addr, bus.f_addr); end
        bus.i_ready        = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'h8 || bus.f_valid !== 1'b0) begin failures++; $display("FAIL rs_hold0 got=%b/%h/%b exp=1/00000008/0", bus.i_valid, bus.i_addr, bus.f_valid); end
        for (int k = 1; k < 3; k++) begin
            step();
            checks++; if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'h8 || bus.f_valid !== 1'b0) begin failures++; $display("FAIL rs_hold k=%0d got=%b/%h/%b exp=1/00000008/0", k, bus.i_valid, bus.i_addr, bus.f_valid); end
        end
        bus.i_ready = 1'b1;
        step();
        checks++; if (bus.i_addr !== 32'h100 || bus.f_valid !== 1'b0) begin failures++; $display("FAIL rs_drop got=%h/%b exp=00000100/0", bus.i_addr, bus.f_valid); end
        step();
        checks++; if (bus.f_valid !== 1'b1 || bus.f_addr !== 32'h100 || bus.f_inst !== 32'hA5A5_0100) begin failures++; $display("FAIL rs_new got=%b/%h/%h exp=1/00000100/a5a50100", bus.f_valid, bus.f_addr, bus.f_inst); end
    endtask

    task automatic test_redirect_complete();
        do_reset(1'b1, 1'b0);
        repeat (3) step();
        checks++; if (bus.i_addr !== 32'h8 || bus.f_addr !== 32'h0) begin failures++; $display("FAIL rc_setup got=%h/%h exp=00000008/00000000", bus.i_addr, bus.f_addr); end
        bus.f_ready        = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.f_valid !== 1'b0 || bus.i_valid !== 1'b1 || bus.i_addr !== 32'h200) begin failures++; $display("FAIL rc_flush got=%b/%b/%h exp=0/1/00000200", bus.f_valid, bus.i_valid, bus.i_addr); end
        step();
        checks++; if (bus.f_valid !== 1'b1 || bus.f_addr !== 32'h200) begin failures++; $display("FAIL rc_next got=%b/%h exp=1/00000200", bus.f_valid, bus.f_addr); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFFE;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.i_addr !== 32'hFFFF_FFFC || bus.f_valid !== 1'b0) begin failures++; $display("FAIL wrap_tgt got=%h/%b exp=fffffffc/0", bus.i_addr, bus.f_valid); end
        step();
        checks++; if (bus.i_addr !== 32'h0 || bus.f_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_next got=%h/%h exp=00000000/fffffffc", bus.i_addr, bus.f_addr); end
        step();
        checks++; if (bus.f_addr !== 32'h0 || bus.f_inst !== 32'hA5A5_0000) begin failures++; $display("FAIL wrap_head got=%h/%h exp=00000000/a5a50000", bus.f_addr, bus.f_inst); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b0);
        repeat (4) step();
        bus.i_ready = 1'b0;
        step();
        checks++; if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'hC || bus.f_valid !== 1'b1) begin failures++; $display("FAIL rm_setup got=%b/%h/%b exp=1/0000000c/1", bus.i_valid, bus.i_addr, bus.f_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.i_valid !== 1'b0 || bus.f_valid !== 1'b0) begin failures++; $display("FAIL rm_async got=%b/%b exp=0/0", bus.i_valid, bus.f_valid); end
        step();
        reset       = 1'b0;
        bus.i_ready = 1'b1;
        step();
        checks++; if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'h0 || bus.f_valid !== 1'b0) begin failures++; $display("FAIL rm_restart got=%b/%h/%b exp=1/00000000/0", bus.i_valid, bus.i_addr, bus.f_valid); end
    endtask

    initial begin
        reset              = 1'b1;
        bus.i_ready        = 1'b0;
        bus.f_ready        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stall();
        test_redirect_complete();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vigna_prefetch.md
# vigna_prefetch

Parametrised instruction prefetch unit for the vigna core family. It replaces single-shot fetch with a DEPTH-entry instruction queue that streams sequential words over the valid/ready instruction bus while the back end executes. A redirect port accepts taken-branch and jump targets, flushing the queue and discarding stale bus responses. It sits between the instruction memory port and the core's decode/execute stage.

## Interface
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  out  1  fetch request valid; held until i_ready.
- i_ready  in  1  memory accepts request and returns i_rdata in the same cycle.
- i_addr  out  32  fetch address, bits [1:0] always 0.
- i_rdata  in  32  instruction word, sampled when i_valid && i_ready.
- i_wdata  out  32  constant 0.
- i_wstrb  out  4  constant 0.
- f_valid  out  1  queue head valid.
- f_ready  in  1  core consumes head.
- f_inst  out  32  head instruction.
- f_addr  out  32  head instruction address.
- redirect_valid  in  1  flush and restart fetch.
- redirect_addr  in  32  new fetch address; bits [1:0] ignored.

## Operation
- Internal state: fetch pointer pc, circular queue of {addr, inst} with read/write pointers and count (0..DEPTH), discard flag.
- Issue rule: at most one outstanding request. A new request is issued (i_valid<=1, i_addr<=pc) when none is outstanding or one completes this cycle, and count_next < DEPTH, where count_next includes this cycle's push and pop. pc advances by 4 on each issue.
- Completion (i_valid && i_ready): if discard=0 and no redirect this cycle, push {i_addr, i_rdata}; else drop the word and clear discard.
- Pop: f_valid && f_ready removes head; f_inst/f_addr show the next entry the following cycle.
- Push and pop in the same cycle: count unchanged. Push into a full queue cannot occur because of the issue rule.
- Redirect (highest priority): queue emptied (count<=0, f_valid<=0), pc<=redirect_addr with [1:0] cleared. A pop in the same cycle counts as accepted and is then flushed.
  - If a request is outstanding and does not complete this cycle: i_valid and i_addr stay unchanged (no bus abort) and discard<=1.
  - If the request completes this cycle: the word is dropped, and i_addr<=redirect target with i_valid=1 at that edge.
  - If idle: next edge i_valid=1, i_addr=target.
  - Redirect while discard=1: updates pc only; discard stays 1.
- Addresses wrap modulo 2^32 (0xFFFF_FFFC+4 → 0).

## Timing
- Reset values: i_valid=0, i_addr=RESET_ADDR, f_valid=0, f_inst=0, f_addr=0, count=0, discard=0, pc=RESET_ADDR. Asserting reset mid-transfer drops i_valid immediately.
- First edge after reset release: i_valid=1, i_addr=RESET_ADDR.
- Fetch latency: a word accepted at edge N is visible at f_valid/f_inst after edge N, usable at edge N+1.
- Zero-wait memory with f_ready held high: sustained one instruction per cycle, with back-to-back i_valid.
- Redirect to first new instruction with an idle bus and zero-wait memory: request at edge R+1, f_valid after edge R+2.
- i_addr and i_valid are stable while i_valid=1 && !i_ready.

## Test plan
- Reset release, i_ready=1, f_ready=1, i_rdata=addr^0xA5A5_0000: f_addr 0,4,8,… one per cycle; f_inst matches.
- f_ready=0, DEPTH=4: exactly 4 words pushed, then i_valid stays 0. Raising f_ready resumes fetching; no entry is lost or duplicated.
- Redirect to 0x100 while a request to 0x8 stalls 3 cycles: i_addr stays 0x8 until ready, the 0x8 word is never presented, and the next request is at 0x100.
- Redirect in the same cycle as completion plus pop on a 2-entry queue: queue empty next cycle, i_addr=0x200; the next f_addr is 0x200.
- Redirect to 0xFFFF_FFFE: i_addr=0xFFFF_FFFC then 0x0.
- Reset asserted mid-stall with 3 queued entries: i_valid and f_valid drop asynchronously; after release, fetch restarts at RESET_ADDR.
